ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard.
//  Pairs with the ps2 receive block on the same PS2_clk/PS2_data pins. Drives both pins open-drain; the top level ties pin = oe ? 1'b0 : 1'bz.
//  Sits in the SOC beside the receiver, clocked from the 50 MHz divider tap. MIO_BUS supplies the command byte.
// PARAMETERS
//  INHIBIT_CYC  5000     clk cycles ps2_clk is held low before the start bit (100 us @ 50 MHz)
//  TIMEOUT_CYC  1000000  max clk cycles between filtered ps2 clock edges once the device clocks (20 ms @ 50 MHz)
//  FILTER_LEN   8        consecutive equal synchronised samples needed to change filtered ps2 clock (2..16)
// PORTS
//  clk          in   1  system clock (50 MHz)
//  RSTN         in   1  async active-low reset
//  tx_data      in   8  command byte
//  tx_valid     in   1  request; accepted when tx_valid & tx_ready
//  tx_ready     out  1  1 only in IDLE
//  ps2_clk_in   in   1  raw PS2_clk pin level (async)
//  ps2_data_in  in   1  raw PS2_data pin level (async)
//  ps2_clk_oe   out  1  1 = pull PS2_clk low
//  ps2_data_oe  out  1  1 = pull PS2_data low
//  rx_inhibit   out  1  1 while not IDLE; receiver discards frames
//  done         out  1  1-cycle pulse: byte sent and ACKed
//  err          out  1  1-cycle pulse: transfer aborted
//  err_code     out  2  01 timeout, 10 no ACK; held until next accept
// BEHAVIOUR
//  Reset (async): state IDLE. Outputs: tx_ready=1, err_code=00; all other outputs 0. Lines are released immediately, also mid-frame.
//  Inputs pass a 2-FF synchroniser. Filtered clock changes after FILTER_LEN equal samples. Falling edge = filtered 1->0.
//  Accept: byte latched, par = ~^tx_data (odd parity), bit counter n=0, err_code cleared.
//  States:
//   IDLE -> INHIBIT on accept.
//   INHIBIT: clk_oe=1 for INHIBIT_CYC cycles. data_oe=1 in the last cycle (start bit). -> START.
//   START: clk_oe=0, data_oe=1. Timeout timer runs. On falling edge: n=n+1, drive bit -> SHIFT.
//   SHIFT: falling edge n=1..8 drives data_oe=~tx_data[n-1] (LSB first). n=9 drives ~par. n=10 releases data (stop) -> ACK.
//   ACK: on falling edge 11, sample data. 0 -> WAIT_IDLE; 1 -> FAIL with code 10.
//   WAIT_IDLE: both filtered lines high -> IDLE and done=1.
//   FAIL: release lines, err=1 and err_code set for one cycle -> IDLE.
//  Timeout: timer cleared on every filtered clk edge and on entering START. Reaching TIMEOUT_CYC in START..WAIT_IDLE -> FAIL with code 01.
//  tx_valid while busy is ignored; no queueing. tx_data is sampled only at accept.
//  Drive changes happen within FILTER_LEN+3 clk of the pin falling edge, well inside the 5 us low phase.
//  done and err never assert in the same cycle. rx_inhibit = (state != IDLE).
// CONFIGURATION
//  PS2_TX_RETRY_EN defined: on no ACK (not timeout), the latched byte is resent from INHIBIT up to 2 more times.
//   err with code 10 fires only after the 3rd failure. A retry counter resets on accept. tx_ready stays 0 throughout.
//  Undefined: the first no-ACK goes straight to FAIL with code 10.
// TESTING
//  Device model clocks 40 us period. Send 0xED -> data_oe pattern bits 1,0,1,1,0,1,1,1; parity 1; model ACKs -> done pulse, err_code 00.
//  Send 0xF4 -> parity 0 on edge 9. clk_oe high exactly 5000 cycles. tx_ready=0 from accept to done.
//  Model stops clocking after edge 4 -> after 1000000 idle cycles both oe=0, err=1, err_code=01.
//  Model leaves data high at edge 11 -> err_code=10 (RETRY_EN: 3 full frames seen, then err).
//  Assert RSTN low at edge 6 -> oe outputs 0 asynchronously. After release: IDLE, tx_ready=1.
//  10 ns glitches on ps2_clk_in (< FILTER_LEN) -> no bit advance. tx_valid pulsed mid-frame -> ignored.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Sends one command byte to the keyboard over the
// shared PS2_clk/PS2_data pins using open-drain drive (pin = oe ? 1'b0 : 1'bz at top level).
//
// Ports:
//   clk          system clock
//   RSTN         asynchronous active-low reset
//   tx_data      command byte, sampled only at accept
//   tx_valid     request; accepted when tx_valid & tx_ready
//   tx_ready     high only while idle
//   ps2_clk_in   raw PS2_clk pin level (asynchronous)
//   ps2_data_in  raw PS2_data pin level (asynchronous)
//   ps2_clk_oe   1 = pull PS2_clk low
//   ps2_data_oe  1 = pull PS2_data low
//   rx_inhibit   high while a transfer is in progress; receiver discards frames
//   done         one-cycle pulse: byte sent and acknowledged
//   err          one-cycle pulse: transfer aborted
//   err_code     01 timeout, 10 no acknowledge; held until the next accept
//
// Build option: define PS2_TX_RETRY_EN to resend the latched byte up to two more times
// after a missing acknowledge before reporting the error.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYC = 5000,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned FILTER_LEN  = 8
) (
  input  logic       clk,
  input  logic       RSTN,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       rx_inhibit,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned FW     = $clog2(FILTER_LEN);
  localparam int unsigned TmrMax = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int unsigned TW     = $clog2(TmrMax + 1);

  typedef enum logic [2:0] {
    StIdle, StInhibit, StStart, StShift, StAck, StWaitIdle, StFail
  } state_e;

  // Synchronisers and glitch filters. Lines idle high, so everything resets to 1.
  logic [1:0]    clk_sync_q, data_sync_q;
  logic [FW-1:0] clk_cnt_q, data_cnt_q;
  logic          clk_f_q, data_f_q, clk_f_prev_q;
  logic          clk_fall, clk_edge;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      clk_cnt_q    <= '0;
      data_cnt_q   <= '0;
      clk_f_q      <= 1'b1;
      data_f_q     <= 1'b1;
      clk_f_prev_q <= 1'b1;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q  <= {data_sync_q[0], ps2_data_in};
      clk_f_prev_q <= clk_f_q;
      // Filtered level flips on the FILTER_LEN-th consecutive differing sample.
      if (clk_sync_q[1] == clk_f_q) begin
        clk_cnt_q <= '0;
      end else if (clk_cnt_q == FW'(FILTER_LEN - 1)) begin
        clk_f_q   <= clk_sync_q[1];
        clk_cnt_q <= '0;
      end else begin
        clk_cnt_q <= clk_cnt_q + FW'(1);
      end
      if (data_sync_q[1] == data_f_q) begin
        data_cnt_q <= '0;
      end else if (data_cnt_q == FW'(FILTER_LEN - 1)) begin
        data_f_q   <= data_sync_q[1];
        data_cnt_q <= '0;
      end else begin
        data_cnt_q <= data_cnt_q + FW'(1);
      end
    end
  end

  assign clk_fall = clk_f_prev_q & ~clk_f_q;
  assign clk_edge = clk_f_prev_q ^ clk_f_q;

  state_e        state_q;
  logic [3:0]    n_q;
  logic [7:0]    byte_q;
  logic          par_q;
  logic [TW-1:0] tmr_q;
  logic          clk_oe_q, data_oe_q, done_q, err_q;
  logic [1:0]    err_code_q, fail_code_q;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]    retry_q;
`endif

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= StIdle;
      n_q         <= '0;
      byte_q      <= '0;
      par_q       <= 1'b0;
      tmr_q       <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      fail_code_q <= 2'b00;
`ifdef PS2_TX_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (tx_valid) begin
            byte_q     <= tx_data;
            par_q      <= ~^tx_data;
            n_q        <= '0;
            err_code_q <= 2'b00;
            tmr_q      <= '0;
            clk_oe_q   <= 1'b1;
            data_oe_q  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= '0;
`endif
            state_q    <= StInhibit;
          end
        end
        StInhibit: begin
          if (tmr_q == TW'(INHIBIT_CYC - 1)) begin
            clk_oe_q <= 1'b0;
            tmr_q    <= '0;
            state_q  <= StStart;
          end else begin
            tmr_q <= tmr_q + TW'(1);
            // Start bit overlaps the final inhibit cycle.
            if (tmr_q == TW'(INHIBIT_CYC - 2)) data_oe_q <= 1'b1;
          end
        end
        StStart, StShift, StAck, StWaitIdle: begin
          if (!clk_edge && tmr_q == TW'(TIMEOUT_CYC - 1)) begin
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            fail_code_q <= 2'b01;
            state_q     <= StFail;
          end else begin
            tmr_q <= clk_edge ? '0 : tmr_q + TW'(1);
            case (state_q)
              StStart: begin
                if (clk_fall) begin
                  n_q       <= 4'd1;
                  data_oe_q <= ~byte_q[0];
                  state_q   <= StShift;
                end
              end
              StShift: begin
                if (clk_fall) begin
                  n_q <= n_q + 4'd1;
                  if (n_q <= 4'd7) begin
                    data_oe_q <= ~byte_q[n_q[2:0]];
                  end else if (n_q == 4'd8) begin
                    data_oe_q <= ~par_q;
                  end else begin
                    data_oe_q <= 1'b0;   // stop bit: release data
                    state_q   <= StAck;
                  end
                end
              end
              StAck: begin
                if (clk_fall) begin
                  n_q <= n_q + 4'd1;
                  if (!data_f_q) begin
                    state_q <= StWaitIdle;
`ifdef PS2_TX_RETRY_EN
                  end else if (retry_q != 2'd2) begin
                    retry_q   <= retry_q + 2'd1;
                    n_q       <= '0;
                    tmr_q     <= '0;
                    clk_oe_q  <= 1'b1;
                    data_oe_q <= 1'b0;
                    state_q   <= StInhibit;
`endif
                  end else begin
                    fail_code_q <= 2'b10;
                    state_q     <= StFail;
                  end
                end
              end
              default: begin
                if (clk_f_q && data_f_q) begin
                  done_q  <= 1'b1;
                  state_q <= StIdle;
                end
              end
            endcase
          end
        end
        StFail: begin
          clk_oe_q   <= 1'b0;
          data_oe_q  <= 1'b0;
          err_q      <= 1'b1;
          err_code_q <= fail_code_q;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_ready    = (state_q == StIdle);
  assign rx_inhibit  = (state_q != StIdle);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int unsigned INH = 40;
  localparam int unsigned TMO = 1500;
  localparam int unsigned FL  = 4;
  localparam int          HP  = 25;   // device clock half period in system cycles
`ifdef PS2_TX_RETRY_EN
  localparam int NFR = 3;
`else
  localparam int NFR = 1;
`endif

  logic       clk, RSTN;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       rx_inhibit, done, err;
  logic [1:0] err_code;

  logic dev_clk_low, dev_data_low, glitch;

  // Wired-AND open-drain lines with pull-ups.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | glitch);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .FILTER_LEN(FL)) dut (
    .clk(clk), .RSTN(RSTN), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .rx_inhibit(rx_inhibit), .done(done), .err(err),
    .err_code(err_code)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic       done;
    logic       err;
    logic [1:0] code;
    logic       clk_oe;
    logic       data_oe;
    logic       ready;
    int         cyc;
  } obs_t;

  logic       bit_q[$];   // expected line level at each device sample
  logic [2:0] out_q[$];   // expected outcome {is_err, err_code}
  obs_t       obs_q[$];   // observed done/err pulses

  int  checks = 0, errors = 0;
  int  cyc = 0;
  bit  busy = 0;
  int  ready_viol = 0, both_viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy && tx_ready && !done && !err) ready_viol++;
    if (done && err) both_viol++;
    if (done === 1'b1 || err === 1'b1)
      obs_q.push_back('{done, err, err_code, ps2_clk_oe, ps2_data_oe, tx_ready, cyc});
  end

  task automatic send(input logic [7:0] b, input int nframes, input bit push_out,
                      input logic [2:0] outc);
    int ones;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL send_ready: tx_ready=%b expected 1", tx_ready);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = 1'b1;
    checks++;
    if (rx_inhibit !== 1'b1 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_busy: rx_inhibit=%b tx_ready=%b expected 1 0", rx_inhibit, tx_ready);
    end
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    for (int f = 0; f < nframes; f++) begin
      for (int i = 0; i < 8; i++) bit_q.push_back(b[i]);
      bit_q.push_back((ones % 2) == 0);
      bit_q.push_back(1'b1);
    end
    if (push_out) out_q.push_back(outc);
  endtask

  // Keyboard model: waits for inhibit + request-to-send, then clocks nedges falling edges.
  task automatic dev_frame(input int nedges, input bit ack, input bit check_inh, input bit noise);
    int cnt, ncs;
    logic smp, exp;
    cnt = 0;
    while (ps2_clk_oe !== 1'b1 && cnt < 2000) begin @(negedge clk); cnt++; end
    if (cnt >= 2000) begin
      checks++; errors++; $display("FAIL inhibit_start: clk_oe=%b expected 1", ps2_clk_oe);
      return;
    end
    cnt = 0; ncs = 0;
    while (ps2_clk_oe === 1'b1 && cnt < int'(INH) + 100) begin
      if (ps2_data_oe === 1'b1) ncs++;
      @(negedge clk);
      cnt++;
    end
    if (check_inh) begin
      checks++;
      if (cnt != int'(INH)) begin
        errors++; $display("FAIL inhibit_len: got %0d cycles expected %0d", cnt, INH);
      end
      checks++;
      if (ncs != 1) begin
        errors++; $display("FAIL start_overlap: got %0d cycles expected 1", ncs);
      end
    end
    checks++;
    if (ps2_data_oe !== 1'b1 || ps2_data_in !== 1'b0) begin
      errors++; $display("FAIL start_bit: data_oe=%b expected 1", ps2_data_oe);
    end
    repeat (HP) @(negedge clk);
    for (int e = 1; e <= nedges; e++) begin
      dev_clk_low = 1'b1;
      repeat (HP) @(negedge clk);
      if (e <= 10) begin
        smp = ps2_data_in;
        checks++;
        if (bit_q.size() == 0) begin
          errors++; $display("FAIL frame_bit%0d: got %b expected nothing queued", e, smp);
        end else begin
          exp = bit_q.pop_front();
          if (smp !== exp) begin
            errors++; $display("FAIL frame_bit%0d: got %b expected %b", e, smp, exp);
          end
        end
      end
      dev_clk_low = 1'b0;
      if (e == 10 && ack) dev_data_low = 1'b1;
      if (noise) begin
        repeat (8) @(negedge clk);
        glitch = 1'b1;
        if (e == 3) begin tx_data = 8'h5A; tx_valid = 1'b1; end
        repeat (2) @(negedge clk);
        glitch = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (HP - 10) @(negedge clk);
      end else begin
        repeat (HP) @(negedge clk);
      end
      if (e == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_outcome(input string name, input int maxcyc, input int t0, output int dt);
    int cnt;
    obs_t o;
    logic [2:0] e;
    cnt = 0; dt = -1;
    while (obs_q.size() == 0 && cnt < maxcyc) begin @(negedge clk); #1; cnt++; end
    busy = 1'b0;
    checks++;
    if (obs_q.size() == 0) begin
      errors++; $display("FAIL %s_outcome: no done/err within %0d cycles", name, maxcyc);
      if (out_q.size() != 0) void'(out_q.pop_front());
      return;
    end
    o = obs_q.pop_front();
    if (out_q.size() == 0) begin
      errors++; $display("FAIL %s_outcome: unexpected pulse done=%b err=%b", name, o.done, o.err);
      return;
    end
    e = out_q.pop_front();
    if (o.done !== ~e[2] || o.err !== e[2]) begin
      errors++;
      $display("FAIL %s_pulse: done=%b err=%b expected %b %b", name, o.done, o.err, ~e[2], e[2]);
    end
    checks++;
    if (o.code !== e[1:0]) begin
      errors++; $display("FAIL %s_code: err_code=%b expected %b", name, o.code, e[1:0]);
    end
    checks++;
    if (o.clk_oe !== 1'b0 || o.data_oe !== 1'b0 || o.ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: clk_oe=%b data_oe=%b tx_ready=%b expected 0 0 1",
               name, o.clk_oe, o.data_oe, o.ready);
    end
    dt = o.cyc - t0;
  endtask

  task automatic test_reset;
    RSTN = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk_low = 1'b0; dev_data_low = 1'b0; glitch = 1'b0;
    #35;
    checks++;
    if (tx_ready !== 1'b1 || err_code !== 2'b00 || rx_inhibit !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: tx_ready=%b err_code=%b rx_inhibit=%b expected 1 00 0",
               tx_ready, err_code, rx_inhibit);
    end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: clk_oe=%b data_oe=%b done=%b err=%b expected 0 0 0 0",
               ps2_clk_oe, ps2_data_oe, done, err);
    end
    @(negedge clk);
    RSTN = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_send_ed;
    int dt;
    send(8'hED, 1, 1'b1, 3'b000);
    dev_frame(11, 1'b1, 1'b1, 1'b0);
    wait_outcome("ed", 200, cyc, dt);
  endtask

  task automatic test_send_f4;
    int dt;
    send(8'hF4, 1, 1'b1, 3'b000);
    dev_frame(11, 1'b1, 1'b1, 1'b0);
    wait_outcome("f4", 200, cyc, dt);
    checks++;
    if (ready_viol != 0 || both_viol != 0) begin
      errors++;
      $display("FAIL ready_busy: ready_viol=%0d both_viol=%0d expected 0 0", ready_viol, both_viol);
    end
  endtask

  task automatic test_timeout;
    int dt, t0;
    send(8'hA5, 1, 1'b1, 3'b101);
    dev_frame(4, 1'b1, 1'b0, 1'b0);
    t0 = cyc;
    wait_outcome("timeout", int'(TMO) + 200, t0, dt);
    checks++;
    if (dt < int'(TMO) - 40 || dt > int'(TMO) + 5) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles expected %0d..%0d", dt, TMO - 40, TMO + 5);
    end
    bit_q.delete();
  endtask

  task automatic test_nack;
    int dt;
    send(8'hFF, NFR, 1'b1, 3'b110);
    for (int f = 0; f < NFR; f++) dev_frame(11, 1'b0, f == 0, 1'b0);
    wait_outcome("nack", 200, cyc, dt);
    checks++;
    if (bit_q.size() != 0) begin
      errors++; $display("FAIL nack_frames: %0d bits unsent expected 0", bit_q.size());
    end
    bit_q.delete();
  endtask

  task automatic test_glitch_and_ignore;
    int dt, starts;
    send(8'h3C, 1, 1'b1, 3'b000);
    dev_frame(11, 1'b1, 1'b0, 1'b1);
    wait_outcome("glitch", 200, cyc, dt);
    starts = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ps2_clk_oe === 1'b1) starts++;
    end
    checks++;
    if (starts != 0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy_valid: clk_oe cycles=%0d tx_ready=%b expected 0 1", starts, tx_ready);
    end
  endtask

  task automatic test_reset_mid_frame;
    send(8'h96, 1, 1'b0, 3'b000);
    dev_frame(5, 1'b1, 1'b0, 1'b0);
    dev_clk_low = 1'b1;
    repeat (FL + 6) @(negedge clk);
    checks++;
    if (ps2_data_oe !== 1'b1) begin
      errors++; $display("FAIL midframe_bit5: data_oe=%b expected 1", ps2_data_oe);
    end
    busy = 1'b0;
    #3 RSTN = 1'b0;
    #1;
    checks++;
    if (ps2_data_oe !== 1'b0 || ps2_clk_oe !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: data_oe=%b clk_oe=%b tx_ready=%b expected 0 0 1",
               ps2_data_oe, ps2_clk_oe, tx_ready);
    end
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    bit_q.delete(); out_q.delete(); obs_q.delete();
    @(negedge clk);
    RSTN = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || rx_inhibit !== 1'b0 || err_code !== 2'b00) begin
      errors++;
      $display("FAIL after_reset: tx_ready=%b rx_inhibit=%b err_code=%b expected 1 0 00",
               tx_ready, rx_inhibit, err_code);
    end
  endtask

  task automatic test_back_to_back;
    int dt;
    send(8'hF4, 1, 1'b1, 3'b000);
    dev_frame(11, 1'b1, 1'b1, 1'b0);
    wait_outcome("b2b_first", 200, cyc, dt);
    send(8'h81, 1, 1'b1, 3'b000);
    dev_frame(11, 1'b1, 1'b1, 1'b0);
    wait_outcome("b2b_second", 200, cyc, dt);
  endtask

  initial begin
    #4ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_send_ed();
    test_send_f4();
    test_timeout();
    test_nack();
    test_glitch_and_ignore();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
